note_tone_gen: RTL

//  Consumes the 8-bit note code from the melody ROM (one code per beat step) and drives a

---
 rtl/note_tone_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/note_tone_gen.sv
// note_tone_gen: turns an 8-bit melody note code into a square wave on the speaker pin.
// The code is mapped to a half-period through a 12-entry semitone table and an octave shift.
// An optional silent gap is inserted before each new or struck note.
// Codes outside 11..82 are treated as a rest.
module note_tone_gen #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  note,
    input  logic        strike,
    output logic        speaker,
    output logic        active,
    output logic [19:0] half_period
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_TONE = 2'd2
    } state_t;

    // Octave-2 half-period in clocks for pitch class pc (C..B), evaluated at elaboration only.
    function automatic logic [19:0] base_hp(input logic [3:0] pc);
        longint unsigned f_mhz;
        longint unsigned num;
        case (pc)
            4'd0:    f_mhz = 64'd65406;
            4'd1:    f_mhz = 64'd69296;
            4'd2:    f_mhz = 64'd73416;
            4'd3:    f_mhz = 64'd77782;
            4'd4:    f_mhz = 64'd82407;
            4'd5:    f_mhz = 64'd87307;
            4'd6:    f_mhz = 64'd92499;
            4'd7:    f_mhz = 64'd97999;
            4'd8:    f_mhz = 64'd103826;
            4'd9:    f_mhz = 64'd110000;
            4'd10:   f_mhz = 64'd116541;
            4'd11:   f_mhz = 64'd123471;
            default: f_mhz = 64'd65406;
        endcase
        num = 64'(CLK_HZ) * 64'd500;
        return 20'(num / f_mhz);
    endfunction

    localparam logic [19:0] BASE [0:11] = '{
        base_hp(4'd0), base_hp(4'd1), base_hp(4'd2),  base_hp(4'd3),
        base_hp(4'd4), base_hp(4'd5), base_hp(4'd6),  base_hp(4'd7),
        base_hp(4'd8), base_hp(4'd9), base_hp(4'd10), base_hp(4'd11)
    };

    localparam logic [19:0] GAP_LOAD = (GAP_CYCLES > 0) ? 20'(GAP_CYCLES - 1) : 20'd0;
    localparam logic        HAS_GAP  = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

    // A code is playable only inside the table range; everything else is a rest.
    function automatic logic note_valid(input logic [7:0] n);
        return (n >= 8'd11) && (n <= 8'd82);
    endfunction

    // Code -> half-period: semitone table entry shifted down by the octave; 0 for a rest.
    function automatic logic [19:0] map_hp(input logic [7:0] n);
        logic [7:0] idx;
        logic [3:0] pc;
        logic [2:0] oct;
        idx = n - 8'd11;
        pc  = 4'(idx % 8'd12);
        oct = 3'(idx / 8'd12);
        if (note_valid(n)) begin
            return BASE[pc] >> oct;
        end else begin
            return 20'd0;
        end
    endfunction

    logic [7:0]  r_note_q;
    logic [7:0]  r_note_prev;
    logic        r_strike_q;
    logic        r_strike_d;
    logic [19:0] r_half_period;
    logic        r_valid;
    logic        r_change;
    state_t      r_state;
    logic [19:0] r_cnt;
    logic        r_speaker;
    logic        r_active;

    state_t      w_next_state;
    logic [19:0] w_next_cnt;
    logic        w_next_speaker;
    state_t      w_start_state;
    logic [19:0] w_start_cnt;
    logic        w_start_speaker;
    logic        w_restart;
    logic [19:0] w_hp_load;

    // Two-stage input pipeline: sample the code, then register its half-period and change/strike flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_note_q      <= 8'd0;
            r_note_prev   <= 8'd0;
            r_strike_q    <= 1'b0;
            r_strike_d    <= 1'b0;
            r_half_period <= 20'd0;
            r_valid       <= 1'b0;
            r_change      <= 1'b0;
        end else begin
            r_note_q      <= note;
            r_note_prev   <= r_note_q;
            r_strike_q    <= strike;
            r_strike_d    <= r_strike_q;
            r_half_period <= map_hp(r_note_q);
            r_valid       <= note_valid(r_note_q);
            r_change      <= (r_note_q != r_note_prev);
        end
    end

    assign w_hp_load = r_half_period - 20'd1;

    // Where a (re)articulated note begins: in the silent gap if one is configured, else straight into the tone.
    always_comb begin
        w_start_state   = ST_TONE;
        w_start_cnt     = w_hp_load;
        w_start_speaker = 1'b1;
        if (HAS_GAP) begin
            w_start_state   = ST_GAP;
            w_start_cnt     = GAP_LOAD;
            w_start_speaker = 1'b0;
        end else begin
            w_start_state   = ST_TONE;
            w_start_cnt     = w_hp_load;
            w_start_speaker = 1'b1;
        end
    end

    // FSM next state: rest/disable forces IDLE; a new code or a strike restarts; otherwise count down.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_speaker = r_speaker;
        w_restart      = r_valid && (r_change || r_strike_d);
        if (!en || !r_valid) begin
            w_next_state   = ST_IDLE;
            w_next_cnt     = 20'd0;
            w_next_speaker = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state   = w_start_state;
                    w_next_cnt     = w_start_cnt;
                    w_next_speaker = w_start_speaker;
                end
                ST_GAP: begin
                    if (w_restart) begin
                        w_next_state   = w_start_state;
                        w_next_cnt     = w_start_cnt;
                        w_next_speaker = w_start_speaker;
                    end else if (r_cnt == 20'd0) begin
                        w_next_state   = ST_TONE;
                        w_next_cnt     = w_hp_load;
                        w_next_speaker = 1'b1;
                    end else begin
                        w_next_cnt     = r_cnt - 20'd1;
                        w_next_speaker = 1'b0;
                    end
                end
                ST_TONE: begin
                    if (w_restart) begin
                        w_next_state   = w_start_state;
                        w_next_cnt     = w_start_cnt;
                        w_next_speaker = w_start_speaker;
                    end else if (r_cnt == 20'd0) begin
                        w_next_cnt     = w_hp_load;
                        w_next_speaker = ~r_speaker;
                    end else begin
                        w_next_cnt     = r_cnt - 20'd1;
                    end
                end
                default: begin
                    w_next_state   = ST_IDLE;
                    w_next_cnt     = 20'd0;
                    w_next_speaker = 1'b0;
                end
            endcase
        end
    end

    // FSM state, shared gap/tone counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 20'd0;
            r_speaker <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_speaker <= w_next_speaker;
            r_active  <= (w_next_state == ST_TONE);
        end
    end

    assign speaker     = r_speaker;
    assign active      = r_active;
    assign half_period = r_half_period;

endmodule
